// File: rtl/mole_hit_detector.sv
// mole_hit_detector: turns synchronised switch toggles into scoring events.
// A toggle on a lit, not-yet-struck mole is a hit. A toggle on an unlit
// position is a miss. Hits feed a pending-point counter that is drained one
// point per cycle onto mole_hit. A consecutive-hit combo awards a bonus point
// once it has saturated.
module mole_hit_detector #(
  parameter int N_MOLES   = 18,
  parameter int COMBO_MAX = 7,
  parameter int PEND_W    = 5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           restart,
  input  logic [N_MOLES-1:0]             sw,
  input  logic [N_MOLES-1:0]             moles,
  output logic                           mole_hit,
  output logic                           miss,
  output logic [N_MOLES-1:0]             whacked,
  output logic [$clog2(COMBO_MAX+1)-1:0] combo
);

  localparam int COMBO_W = $clog2(COMBO_MAX + 1);
  // One cycle can award at most two points per mole (base plus bonus).
  localparam int PTS_W   = $clog2(2 * N_MOLES + 1);
  localparam int SUM_W   = PEND_W + PTS_W;
  localparam logic [COMBO_W-1:0] COMBO_SAT = COMBO_W'(COMBO_MAX);
  localparam logic [SUM_W-1:0]   PEND_SAT  = SUM_W'((1 << PEND_W) - 1);
  localparam logic [1:0]         ARM_DONE  = 2'd3;

  // Number of set bits in a mole vector.
  function automatic logic [PTS_W-1:0] popcount(input logic [N_MOLES-1:0] v);
    logic [PTS_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      c = c + PTS_W'(v[i]);
    end
    return c;
  endfunction

  logic [N_MOLES-1:0] s1_q, s1_d;
  logic [N_MOLES-1:0] s2_q, s2_d;
  logic [N_MOLES-1:0] prev_q, prev_d;
  logic [N_MOLES-1:0] whacked_q, whacked_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               miss_q, miss_d;
  logic [1:0]         arm_q, arm_d;

  logic [N_MOLES-1:0] strike_s;
  logic [N_MOLES-1:0] hits_s;
  logic               miss_any_s;
  logic [PTS_W-1:0]   points_s;
  logic [COMBO_W-1:0] combo_v_s;
  logic [SUM_W-1:0]   pend_sum_s;

  // Strike qualification, hit/miss classification, combo scoring and the
  // pending-point counter; restart overrides everything at the end.
  always_comb begin
    s1_d      = sw;
    s2_d      = s1_q;
    prev_d    = s2_q;

    // Strikes are masked until the arm counter reaches 3 so that switches
    // already up at power-on or restart do not register as strikes.
    if (arm_q == ARM_DONE) begin
      strike_s = s2_q ^ prev_q;
      arm_d    = arm_q;
    end else begin
      strike_s = '0;
      arm_d    = arm_q + 2'd1;
    end

    hits_s     = strike_s & moles & ~whacked_q;
    miss_any_s = |(strike_s & ~moles);
    whacked_d  = (whacked_q | hits_s) & moles;
    miss_d     = miss_any_s;

    combo_v_s = combo_q;
    points_s  = '0;
    if (miss_any_s) begin
      // A miss breaks the combo; same-cycle hits score base value only.
      combo_v_s = '0;
      points_s  = popcount(hits_s);
    end else begin
      // Hits are scored in index order so the bonus applies from the hit
      // that finds the combo already saturated.
      for (int i = 0; i < N_MOLES; i++) begin
        if (hits_s[i]) begin
          if (combo_v_s == COMBO_SAT) begin
            points_s = points_s + PTS_W'(2);
          end else begin
            points_s  = points_s + PTS_W'(1);
            combo_v_s = combo_v_s + COMBO_W'(1);
          end
        end else begin
          points_s = points_s;
        end
      end
    end
    combo_d = combo_v_s;

    pend_sum_s = SUM_W'(pend_q) - SUM_W'(pend_q != '0) + SUM_W'(points_s);
    if (pend_sum_s > PEND_SAT) begin
      pend_d = PEND_SAT[PEND_W-1:0];
    end else begin
      pend_d = pend_sum_s[PEND_W-1:0];
    end

    if (restart) begin
      pend_d    = '0;
      combo_d   = '0;
      whacked_d = '0;
      miss_d    = 1'b0;
      prev_d    = s2_q;
      arm_d     = 2'd0;
    end else begin
      arm_d = arm_d;
    end
  end

  // State registers: synchroniser, edge history, scoring state, arm counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      whacked_q <= '0;
      pend_q    <= '0;
      combo_q   <= '0;
      miss_q    <= 1'b0;
      arm_q     <= 2'd0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      whacked_q <= whacked_d;
      pend_q    <= pend_d;
      combo_q   <= combo_d;
      miss_q    <= miss_d;
      arm_q     <= arm_d;
    end
  end

  assign mole_hit = (pend_q != '0);
  assign miss     = miss_q;
  assign whacked  = whacked_q;
  assign combo    = combo_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector: one task per scenario, inline checks.
module tb_mole_hit_detector;

  logic        clk;
  logic        reset_n;
  logic        restart;
  logic [17:0] sw;
  logic [17:0] moles;
  logic        mole_hit;
  logic        miss;
  logic [17:0] whacked;
  logic [2:0]  combo;

  int n_cmp = 0;
  int n_bad = 0;

  mole_hit_detector #(.N_MOLES(18), .COMBO_MAX(7), .PEND_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .sw(sw), .moles(moles),
    .mole_hit(mole_hit), .miss(miss), .whacked(whacked), .combo(combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    int hits;
    int misses;
    reset_n = 1'b0; restart = 1'b0; sw = 18'h3FFFF; moles = 18'h0;
    repeat (3) tick();
    n_cmp++;
    if ({mole_hit, miss, whacked, combo} !== 23'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %0h want 0", {mole_hit, miss, whacked, combo});
    end
    reset_n = 1'b1;
    hits = 0; misses = 0;
    repeat (10) begin
      tick();
      if (mole_hit) hits++;
      if (miss) misses++;
    end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL reset_hits: got %0d want 0", hits); end
    n_cmp++;
    if (misses !== 0) begin n_bad++; $display("FAIL reset_miss: got %0d want 0", misses); end
    n_cmp++;
    if (whacked !== 18'h0) begin n_bad++; $display("FAIL reset_whacked: got %0h want 0", whacked); end
    n_cmp++;
    if (combo !== 3'd0) begin n_bad++; $display("FAIL reset_combo: got %0d want 0", combo); end
  endtask

  task automatic test_single_hit();
    int hits;
    int misses;
    moles = 18'h00010;
    sw[4] = ~sw[4];
    tick(); tick();
    n_cmp++;
    if (mole_hit !== 1'b0) begin n_bad++; $display("FAIL single_early: got %0b want 0", mole_hit); end
    tick();
    n_cmp++;
    if (mole_hit !== 1'b1) begin n_bad++; $display("FAIL single_hit: got %0b want 1", mole_hit); end
    n_cmp++;
    if (whacked !== 18'h00010) begin n_bad++; $display("FAIL single_whacked: got %0h want 10", whacked); end
    n_cmp++;
    if (combo !== 3'd1) begin n_bad++; $display("FAIL single_combo: got %0d want 1", combo); end
    n_cmp++;
    if (miss !== 1'b0) begin n_bad++; $display("FAIL single_miss: got %0b want 0", miss); end
    tick();
    n_cmp++;
    if (mole_hit !== 1'b0) begin n_bad++; $display("FAIL single_pulse_len: got %0b want 0", mole_hit); end
    // Second strike on the same lit, already-whacked mole is ignored.
    sw[4] = ~sw[4];
    hits = 0; misses = 0;
    repeat (8) begin
      tick();
      if (mole_hit) hits++;
      if (miss) misses++;
    end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL rewhack_hits: got %0d want 0", hits); end
    n_cmp++;
    if (misses !== 0) begin n_bad++; $display("FAIL rewhack_miss: got %0d want 0", misses); end
    moles = 18'h0;
    tick();
    n_cmp++;
    if (whacked !== 18'h0) begin n_bad++; $display("FAIL whacked_clear: got %0h want 0", whacked); end
    do_restart();
  endtask

  task automatic test_simultaneous();
    moles = 18'h00011;
    sw = sw ^ 18'h00011;
    repeat (3) tick();
    n_cmp++;
    if (mole_hit !== 1'b1) begin n_bad++; $display("FAIL dual_first: got %0b want 1", mole_hit); end
    n_cmp++;
    if (combo !== 3'd2) begin n_bad++; $display("FAIL dual_combo: got %0d want 2", combo); end
    n_cmp++;
    if (whacked !== 18'h00011) begin n_bad++; $display("FAIL dual_whacked: got %0h want 11", whacked); end
    tick();
    n_cmp++;
    if (mole_hit !== 1'b1) begin n_bad++; $display("FAIL dual_second: got %0b want 1", mole_hit); end
    tick();
    n_cmp++;
    if (mole_hit !== 1'b0) begin n_bad++; $display("FAIL dual_end: got %0b want 0", mole_hit); end
    moles = 18'h0;
    do_restart();
  endtask

  task automatic test_combo_saturation();
    int total;
    int cnt;
    int exp_combo;
    int exp_cnt;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      moles = 18'h0;
      moles[i] = 1'b1;
      sw[i] = ~sw[i];
      cnt = 0;
      repeat (6) begin
        tick();
        if (mole_hit) cnt++;
      end
      exp_combo = (i < 7) ? i + 1 : 7;
      exp_cnt   = (i == 7) ? 2 : 1;
      n_cmp++;
      if (combo !== exp_combo[2:0]) begin
        n_bad++; $display("FAIL combo_step%0d: got %0d want %0d", i, combo, exp_combo);
      end
      n_cmp++;
      if (cnt !== exp_cnt) begin
        n_bad++; $display("FAIL combo_pts%0d: got %0d want %0d", i, cnt, exp_cnt);
      end
      total += cnt;
    end
    n_cmp++;
    if (total !== 9) begin n_bad++; $display("FAIL combo_total: got %0d want 9", total); end
    moles = 18'h0;
    do_restart();
  endtask

  task automatic test_miss_priority();
    for (int i = 10; i < 15; i++) begin
      moles = 18'h0;
      moles[i] = 1'b1;
      sw[i] = ~sw[i];
      repeat (6) tick();
    end
    n_cmp++;
    if (combo !== 3'd5) begin n_bad++; $display("FAIL miss_setup_combo: got %0d want 5", combo); end
    moles = 18'h00010;
    sw = sw ^ 18'h00014;
    repeat (3) tick();
    n_cmp++;
    if (miss !== 1'b1) begin n_bad++; $display("FAIL miss_pulse: got %0b want 1", miss); end
    n_cmp++;
    if (mole_hit !== 1'b1) begin n_bad++; $display("FAIL miss_hit: got %0b want 1", mole_hit); end
    n_cmp++;
    if (combo !== 3'd0) begin n_bad++; $display("FAIL miss_combo: got %0d want 0", combo); end
    tick();
    n_cmp++;
    if (miss !== 1'b0) begin n_bad++; $display("FAIL miss_len: got %0b want 0", miss); end
    n_cmp++;
    if (mole_hit !== 1'b0) begin n_bad++; $display("FAIL miss_hit_len: got %0b want 0", mole_hit); end
    moles = 18'h0;
    do_restart();
  endtask

  task automatic test_restart();
    int hits;
    int misses;
    moles = 18'h00007;
    sw = sw ^ 18'h00007;
    repeat (3) tick();
    n_cmp++;
    if (mole_hit !== 1'b1) begin n_bad++; $display("FAIL rst_setup_hit: got %0b want 1", mole_hit); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++;
    if (mole_hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit: got %0b want 0", mole_hit); end
    n_cmp++;
    if (combo !== 3'd0) begin n_bad++; $display("FAIL rst_combo: got %0d want 0", combo); end
    n_cmp++;
    if (whacked !== 18'h0) begin n_bad++; $display("FAIL rst_whacked: got %0h want 0", whacked); end
    // Strike inside the rearm window must be suppressed.
    moles = 18'h00020;
    sw[5] = ~sw[5];
    hits = 0; misses = 0;
    repeat (10) begin
      tick();
      if (mole_hit) hits++;
      if (miss) misses++;
    end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL rst_arm_hits: got %0d want 0", hits); end
    n_cmp++;
    if (misses !== 0) begin n_bad++; $display("FAIL rst_arm_miss: got %0d want 0", misses); end
    n_cmp++;
    if (whacked !== 18'h0) begin n_bad++; $display("FAIL rst_arm_whacked: got %0h want 0", whacked); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_combo_saturation();
    test_miss_priority();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mole_hit_detector.md
# mole_hit_detector

Converts player switch actions into scoring events for the whack-a-mole game. It sits downstream of the mole LED randomiser: it compares synchronised switch toggles against the live mole LED vector. It emits single-cycle `mole_hit` pulses that drive the score counter's increment input, a `miss` pulse, a `whacked` mask fed back to blank struck moles, and a combo count with a double-points bonus.

## Interface
Parameters:
- `N_MOLES`, 18, number of mole positions (LEDs/switches).
- `COMBO_MAX`, 7, combo saturation value; hits at this value score double.
- `PEND_W`, 5, width of the pending-hit counter.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous single-cycle clear (game restart edge).
- `sw`  in  N_MOLES  raw slide switches, asynchronous to `clk`.
- `moles`  in  N_MOLES  active mole LEDs from the randomiser.
- `mole_hit`  out  1  one-cycle pulse per point to award.
- `miss`  out  1  one-cycle pulse, registered, on any strike at an unlit position.
- `whacked`  out  N_MOLES  moles already struck during their current lit period.
- `combo`  out  $clog2(COMBO_MAX+1)  consecutive-hit count, saturating.

## Operation
- Switch input path: 2-FF synchroniser (`s1`, `s2`), then `prev` register. Strike vector `strike = s2 ^ prev`. Both switch directions count as a strike.
- Arm counter: strikes are forced to zero until 3 clock edges after reset deassertion and for 3 edges after `restart`. This suppresses spurious strikes from switches already up.
- Per cycle, with `strike` qualified:
  - `hits = strike & moles & ~whacked`
  - `nh = popcount(hits)`, 0..N_MOLES.
  - `miss_any = |(strike & ~moles)`. Strikes on lit but already-whacked moles are ignored: no hit, no miss.
- `whacked_next = (whacked | hits) & moles`. A bit clears the cycle after its mole LED falls.
- Combo update, with miss taking priority:
  - If `miss_any`, `combo` goes to 0; hits in the same cycle still score at base value with no bonus.
  - Otherwise each hit is processed in index order. Each adds 1 point, plus 1 bonus point if `combo == COMBO_MAX` before that hit. Each increments `combo`, saturating at COMBO_MAX.
- Pending counter `pend` (PEND_W bits):
  - `pend_next = pend - (pend != 0) + points`
  - Saturates at 2^PEND_W-1; excess points are dropped.
- `mole_hit = (pend != 0)`, driven from the register. Consecutive points produce consecutive high cycles. The score counter counts each high cycle.
- `restart` clears `pend`, `combo`, `whacked` and `miss`, loads `prev <= s2`, and rearms the 3-cycle suppression. `restart` has priority over same-cycle strikes.

## Timing
- Reset (async assert, sync release): `s1`, `s2`, `prev`, `pend`, `combo`, `whacked`, `miss` are all 0; arm counter is 0 (disarmed).
- Latency: `sw` change set up before edge k is in `s2` after k+1. `strike` is evaluated in cycle k+1..k+2. `pend`, `whacked`, `combo` and `miss` update at edge k+2. `mole_hit` goes high after edge k+2, i.e. 2 cycles after sampling.
- `moles` is sampled in the same cycle as `strike` (no extra delay).
- `miss` is high exactly one cycle per offending strike cycle.
- A lit mole falling in the same cycle as its strike: `moles` = 0 at that cycle, so the strike is a miss.
- N simultaneous hits produce N (or more, with bonus) back-to-back `mole_hit` cycles.

## Test plan
- Reset with `sw=18'h3FFFF`, `moles=0`, hold 10 cycles -> no `miss`, no `mole_hit`; all outputs 0.
- `moles=18'h00010`, toggle `sw[4]` -> `mole_hit` high exactly 1 cycle 2 cycles later; `whacked=18'h00010`; `combo=1`. Toggle `sw[4]` again -> no hit, no miss.
- `moles=18'h00011`, toggle `sw[0]` and `sw[4]` in the same cycle -> 2 consecutive `mole_hit` cycles; `combo=2`.
- 8 sequential single hits on fresh moles -> `combo` reads 1..7 then stays 7. The 8th hit yields 2 `mole_hit` cycles (total 9).
- Combo at 5, toggle `sw[2]` (unlit) and `sw[4]` (lit) together -> `miss` 1 cycle, `combo=0`, 1 `mole_hit` cycle.
- `pend=3` then `restart` -> `mole_hit` low next cycle, `combo=0`, `whacked=0`. A strike within the next 3 cycles is ignored.
